// File: rtl/dwc_upconv_pkg.sv
// Shared definitions for the AXI4 up-converter (DWC) command path:
// AXI burst encodings, the wrap command sequencer state encoding and a
// helper that derives the slave-side AxSIZE from the slave data width.
package dwc_upconv_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE1 = 2'b01,
        ST_ISSUE2 = 2'b10
    } seq_state_e;

    // log2 of the slave beat size in bytes (AxSIZE encoding of the wide side)
    function automatic logic [2:0] slave_size(input int unsigned data_width_out);
        logic [2:0] res;
        res = 3'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((32'd1 << i) == (data_width_out / 32'd8)) begin
                res = 3'(i);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dwc_upconv_cmd_encode.sv
// Combinational builder of the first (and, for unaligned WRAP, second)
// slave-width command from one master address transaction and its
// pre-calculated wrap/offset values.
module dwc_upconv_cmd_encode
    import dwc_upconv_pkg::*;
#(
    parameter int DATA_WIDTH_OUT = 64,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic [ADDR_WIDTH-1:0] aaddr,
    input  logic [7:0]            alen,
    input  logic [2:0]            asize,
    input  logic [1:0]            aburst,
    input  logic [7:0]            alen_wrap_pre,
    input  logic [7:0]            alen_sec_wrap_pre,
    input  logic [4:0]            to_boundary_master_pre,
    input  logic [9:0]            mask_wrap_addr_pre,
    input  logic [2:0]            size_diff_pre,
    input  logic [5:0]            len_offset_pre,
    input  logic                  wrap_tx_pre,
    input  logic                  fixed_flag_pre,
    output logic [ADDR_WIDTH-1:0] first_addr,
    output logic [7:0]            first_len,
    output logic [2:0]            first_size,
    output logic [1:0]            first_burst,
    output logic [8:0]            first_mst_beats,
    output logic                  first_last_sub,
    output logic                  split,
    output logic [ADDR_WIDTH-1:0] sec_addr,
    output logic [7:0]            sec_len,
    output logic [8:0]            sec_mst_beats
);

    localparam logic [2:0] SLV_SIZE = slave_size(DATA_WIDTH_OUT);

    logic [8:0] beats_total_s;
    logic [8:0] incr_sum_s;

    // Select the command shape by burst kind and derive the wrap second half
    always_comb begin
        beats_total_s   = {1'b0, alen} + 9'd1;
        // offset + len can exceed 255 before the shift, so keep 9 bits
        incr_sum_s      = {3'b000, len_offset_pre} + {1'b0, alen};

        first_addr      = aaddr;
        first_len       = 8'd0;
        first_size      = SLV_SIZE;
        first_burst     = BURST_INCR;
        first_mst_beats = beats_total_s;
        first_last_sub  = 1'b1;
        split           = 1'b0;

        if (fixed_flag_pre) begin
            first_len   = alen;
            first_size  = asize;
            first_burst = BURST_FIXED;
        end else if (wrap_tx_pre && (aburst == BURST_WRAP)) begin
            // unaligned wrap: first INCR runs up to the wrap boundary
            first_len       = alen_wrap_pre;
            first_mst_beats = {4'b0000, to_boundary_master_pre};
            first_last_sub  = 1'b0;
            split           = 1'b1;
        end else if (aburst == BURST_WRAP) begin
            first_len = alen >> size_diff_pre;
        end else begin
            first_len = 8'(incr_sum_s >> size_diff_pre);
        end

        // second half restarts at the bottom of the wrap window
        sec_addr      = {aaddr[ADDR_WIDTH-1:10], aaddr[9:0] & ~mask_wrap_addr_pre};
        sec_len       = alen_sec_wrap_pre;
        sec_mst_beats = beats_total_s - {4'b0000, to_boundary_master_pre};
    end

endmodule

// File: rtl/dwc_upconv_wrap_cmd_sequencer.sv
// Wrap command sequencer of the AXI4 up-converter: turns each accepted
// master address transaction into one slave command (INCR, aligned WRAP,
// FIXED) or two INCR sub-commands (unaligned WRAP). All cmd_* outputs are
// registered and held stable under backpressure.
// Optional build macro DWC_UPCONV_WRAP_SEQ_STATS_EN adds a saturating
// split_count output counting accepted unaligned-WRAP transactions.
module dwc_upconv_wrap_cmd_sequencer
    import dwc_upconv_pkg::*;
#(
    parameter int DATA_WIDTH_OUT = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int USER_WIDTH     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_avalid,
    output logic                  in_aready,
    input  logic [ID_WIDTH-1:0]   in_aid,
    input  logic [ADDR_WIDTH-1:0] in_aaddr,
    input  logic [7:0]            in_alen,
    input  logic [2:0]            in_asize,
    input  logic [1:0]            in_aburst,
    input  logic [USER_WIDTH-1:0] in_auser,
    input  logic [7:0]            alen_wrap_pre,
    input  logic [7:0]            alen_sec_wrap_pre,
    input  logic [4:0]            to_boundary_master_pre,
    input  logic [9:0]            mask_wrap_addr_pre,
    input  logic [2:0]            sizeDiff_pre,
    input  logic [5:0]            len_offset_pre,
    input  logic                  wrap_tx_pre,
    input  logic                  fixed_flag_comb_pre,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ID_WIDTH-1:0]   cmd_id,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]            cmd_len,
    output logic [2:0]            cmd_size,
    output logic [1:0]            cmd_burst,
    output logic [USER_WIDTH-1:0] cmd_user,
    output logic [8:0]            cmd_mst_beats,
    output logic                  cmd_last_sub
`ifdef DWC_UPCONV_WRAP_SEQ_STATS_EN
    ,
    output logic [15:0]           split_count
`endif
);

    localparam logic [2:0] SLV_SIZE = slave_size(DATA_WIDTH_OUT);

    // encoder outputs
    logic [ADDR_WIDTH-1:0] enc_first_addr_s;
    logic [7:0]            enc_first_len_s;
    logic [2:0]            enc_first_size_s;
    logic [1:0]            enc_first_burst_s;
    logic [8:0]            enc_first_beats_s;
    logic                  enc_first_last_s;
    logic                  enc_split_s;
    logic [ADDR_WIDTH-1:0] enc_sec_addr_s;
    logic [7:0]            enc_sec_len_s;
    logic [8:0]            enc_sec_beats_s;

    // state and output registers
    seq_state_e            state_q, state_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic [ID_WIDTH-1:0]   cmd_id_q, cmd_id_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [7:0]            cmd_len_q, cmd_len_d;
    logic [2:0]            cmd_size_q, cmd_size_d;
    logic [1:0]            cmd_burst_q, cmd_burst_d;
    logic [USER_WIDTH-1:0] cmd_user_q, cmd_user_d;
    logic [8:0]            cmd_beats_q, cmd_beats_d;
    logic                  cmd_last_q, cmd_last_d;
    // second sub-command, captured at accept time
    logic                  split_q, split_d;
    logic [ADDR_WIDTH-1:0] sec_addr_q, sec_addr_d;
    logic [7:0]            sec_len_q, sec_len_d;
    logic [8:0]            sec_beats_q, sec_beats_d;

    logic                  in_aready_s;
    logic                  accept_s;

    dwc_upconv_cmd_encode #(
        .DATA_WIDTH_OUT (DATA_WIDTH_OUT),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) u_encode (
        .aaddr                  (in_aaddr),
        .alen                   (in_alen),
        .asize                  (in_asize),
        .aburst                 (in_aburst),
        .alen_wrap_pre          (alen_wrap_pre),
        .alen_sec_wrap_pre      (alen_sec_wrap_pre),
        .to_boundary_master_pre (to_boundary_master_pre),
        .mask_wrap_addr_pre     (mask_wrap_addr_pre),
        .size_diff_pre          (sizeDiff_pre),
        .len_offset_pre         (len_offset_pre),
        .wrap_tx_pre            (wrap_tx_pre),
        .fixed_flag_pre         (fixed_flag_comb_pre),
        .first_addr             (enc_first_addr_s),
        .first_len              (enc_first_len_s),
        .first_size             (enc_first_size_s),
        .first_burst            (enc_first_burst_s),
        .first_mst_beats        (enc_first_beats_s),
        .first_last_sub         (enc_first_last_s),
        .split                  (enc_split_s),
        .sec_addr               (enc_sec_addr_s),
        .sec_len                (enc_sec_len_s),
        .sec_mst_beats          (enc_sec_beats_s)
    );

    // Ready to take a new transaction whenever the output slot frees up this cycle
    always_comb begin
        case (state_q)
            ST_IDLE:   in_aready_s = !rst;
            ST_ISSUE1: in_aready_s = !rst && !split_q && cmd_ready;
            ST_ISSUE2: in_aready_s = !rst && cmd_ready;
            default:   in_aready_s = 1'b0;
        endcase
        accept_s = in_avalid && in_aready_s;
    end

    // Next-state and next-command computation
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_id_d    = cmd_id_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        cmd_size_d  = cmd_size_q;
        cmd_burst_d = cmd_burst_q;
        cmd_user_d  = cmd_user_q;
        cmd_beats_d = cmd_beats_q;
        cmd_last_d  = cmd_last_q;
        split_d     = split_q;
        sec_addr_d  = sec_addr_q;
        sec_len_d   = sec_len_q;
        sec_beats_d = sec_beats_q;

        if (accept_s) begin
            // new transaction takes the output slot directly
            state_d     = ST_ISSUE1;
            cmd_valid_d = 1'b1;
            cmd_id_d    = in_aid;
            cmd_addr_d  = enc_first_addr_s;
            cmd_len_d   = enc_first_len_s;
            cmd_size_d  = enc_first_size_s;
            cmd_burst_d = enc_first_burst_s;
            cmd_user_d  = in_auser;
            cmd_beats_d = enc_first_beats_s;
            cmd_last_d  = enc_first_last_s;
            split_d     = enc_split_s;
            sec_addr_d  = enc_sec_addr_s;
            sec_len_d   = enc_sec_len_s;
            sec_beats_d = enc_sec_beats_s;
        end else if ((state_q == ST_ISSUE1) && cmd_ready && split_q) begin
            // first half delivered: present the wrap second half
            state_d     = ST_ISSUE2;
            cmd_addr_d  = sec_addr_q;
            cmd_len_d   = sec_len_q;
            cmd_size_d  = SLV_SIZE;
            cmd_burst_d = BURST_INCR;
            cmd_beats_d = sec_beats_q;
            cmd_last_d  = 1'b1;
            split_d     = 1'b0;
        end else if ((state_q != ST_IDLE) && cmd_ready) begin
            // last sub-command delivered and nothing new waiting
            state_d     = ST_IDLE;
            cmd_valid_d = 1'b0;
        end else begin
            // idle with no input, or stalled: hold everything
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= {ID_WIDTH{1'b0}};
            cmd_addr_q  <= {ADDR_WIDTH{1'b0}};
            cmd_len_q   <= 8'd0;
            cmd_size_q  <= 3'd0;
            cmd_burst_q <= 2'b00;
            cmd_user_q  <= {USER_WIDTH{1'b0}};
            cmd_beats_q <= 9'd0;
            cmd_last_q  <= 1'b0;
            split_q     <= 1'b0;
            sec_addr_q  <= {ADDR_WIDTH{1'b0}};
            sec_len_q   <= 8'd0;
            sec_beats_q <= 9'd0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_id_q    <= cmd_id_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            cmd_size_q  <= cmd_size_d;
            cmd_burst_q <= cmd_burst_d;
            cmd_user_q  <= cmd_user_d;
            cmd_beats_q <= cmd_beats_d;
            cmd_last_q  <= cmd_last_d;
            split_q     <= split_d;
            sec_addr_q  <= sec_addr_d;
            sec_len_q   <= sec_len_d;
            sec_beats_q <= sec_beats_d;
        end
    end

`ifdef DWC_UPCONV_WRAP_SEQ_STATS_EN
    logic [15:0] split_count_q, split_count_d;

    // Saturating count of accepted unaligned-WRAP transactions
    always_comb begin
        if (accept_s && enc_split_s && (split_count_q != 16'hFFFF)) begin
            split_count_d = split_count_q + 16'd1;
        end else begin
            split_count_d = split_count_q;
        end
    end

    // Split counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            split_count_q <= 16'd0;
        end else begin
            split_count_q <= split_count_d;
        end
    end

    assign split_count = split_count_q;
`endif

    assign in_aready     = in_aready_s;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_id        = cmd_id_q;
    assign cmd_addr      = cmd_addr_q;
    assign cmd_len       = cmd_len_q;
    assign cmd_size      = cmd_size_q;
    assign cmd_burst     = cmd_burst_q;
    assign cmd_user      = cmd_user_q;
    assign cmd_mst_beats = cmd_beats_q;
    assign cmd_last_sub  = cmd_last_q;

endmodule
